// File: rtl/hazard_scheduler.sv
// Issue/stall sequencer for the F/D/E/M/W datapath: RAW interlock against an
// in-flight destination tag pipe, branch shadow FSM, saturating stall counter.
module hazard_scheduler #(
    parameter int DEPTH     = 3,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validD,
    input  logic [3:0]       ra1D,
    input  logic [3:0]       ra2D,
    input  logic             useRa1D,
    input  logic             useRa2D,
    input  logic             regWriteD,
    input  logic [3:0]       wa3D,
    input  logic             branchD,
    input  logic             killE,
    output logic             stallF,
    output logic             stallD,
    output logic             flushE,
    output logic             issueE,
    output logic             branchBusy,
    output logic [CNT_W-1:0] stallCnt
);

    localparam int WIN = DEPTH - WB_BYPASS;
    localparam int SW  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {RUN, WAIT, RELEASE} state_t;

    typedef struct packed {
        logic       v;
        logic [3:0] dst;
    } tag_t;

    state_t        state, state_next;
    logic [SW-1:0] shadow, shadow_next;
    tag_t          tag [DEPTH];
    tag_t          tag0_kept;
    logic          hit1, hit2, hz;

    // A cancelled E instruction never blocks, neither now nor after it shifts.
    always_comb begin
        tag0_kept   = tag[0];
        tag0_kept.v = tag[0].v & ~killE;
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            if (i == 0) begin
                hit1 = hit1 | (tag0_kept.v & (tag0_kept.dst == ra1D));
                hit2 = hit2 | (tag0_kept.v & (tag0_kept.dst == ra2D));
            end else begin
                hit1 = hit1 | (tag[i].v & (tag[i].dst == ra1D));
                hit2 = hit2 | (tag[i].v & (tag[i].dst == ra2D));
            end
        end
        hz = validD & ((useRa1D & hit1) | (useRa2D & hit2));
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        shadow_next = shadow;
        stallF      = 1'b0;
        stallD      = 1'b0;
        flushE      = 1'b0;
        issueE      = 1'b0;
        branchBusy  = 1'b0;
        case (state)
            RUN: begin
                if (hz) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end else if (validD && branchD) begin
                    issueE      = 1'b1;
                    shadow_next = SW'(DEPTH - 1);
                    state_next  = (DEPTH > 1) ? WAIT : RELEASE;
                end else begin
                    issueE = validD;
                    flushE = ~validD;
                end
            end
            WAIT: begin
                branchBusy  = 1'b1;
                stallF      = 1'b1;
                stallD      = 1'b1;
                flushE      = 1'b1;
                shadow_next = shadow - SW'(1);
                if (shadow == SW'(1)) state_next = RELEASE;
            end
            RELEASE: begin
                // Branch is in W; PC loads the redirect, D holds a stale fetch.
                flushE     = 1'b1;
                branchBusy = 1'b1;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
        if (rst) begin
            stallF     = 1'b0;
            stallD     = 1'b0;
            flushE     = 1'b0;
            issueE     = 1'b0;
            branchBusy = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            shadow   <= '0;
            stallCnt <= '0;
            for (int i = 0; i < DEPTH; i++) tag[i] <= '0;
        end else begin
            state  <= state_next;
            shadow <= shadow_next;
            if (stallD && (stallCnt != '1)) stallCnt <= stallCnt + CNT_W'(1);
            tag[0] <= '{v: issueE & regWriteD, dst: wa3D};
            for (int i = 1; i < DEPTH; i++) tag[i] <= (i == 1) ? tag0_kept : tag[i-1];
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: expected output vectors are queued as
// each cycle's stimulus is applied and popped when the outputs settle.
module tb_hazard_scheduler;

    localparam int CNT_W = 4;

    // Expected output vector order: {stallF, stallD, flushE, issueE, branchBusy}
    localparam logic [4:0] E_RST = 5'b00000;
    localparam logic [4:0] E_ISS = 5'b00010;
    localparam logic [4:0] E_IDL = 5'b00100;
    localparam logic [4:0] E_HZ  = 5'b11100;
    localparam logic [4:0] E_WT  = 5'b11101;
    localparam logic [4:0] E_REL = 5'b00101;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } sb_entry_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             validD = 1'b0;
    logic [3:0]       ra1D = '0, ra2D = '0, wa3D = '0;
    logic             useRa1D = 1'b0, useRa2D = 1'b0, regWriteD = 1'b0;
    logic             branchD = 1'b0, killE = 1'b0;
    logic             stallF, stallD, flushE, issueE, branchBusy;
    logic [CNT_W-1:0] stallCnt;

    sb_entry_t sb[$];
    int        checks = 0;
    int        failures = 0;

    hazard_scheduler #(.DEPTH(3), .WB_BYPASS(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .validD(validD), .ra1D(ra1D), .ra2D(ra2D),
        .useRa1D(useRa1D), .useRa2D(useRa2D), .regWriteD(regWriteD), .wa3D(wa3D),
        .branchD(branchD), .killE(killE), .stallF(stallF), .stallD(stallD),
        .flushE(flushE), .issueE(issueE), .branchBusy(branchBusy), .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: apply inputs after the falling edge, queue the expectation,
    // then compare the settled outputs well before the next rising edge.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [3:0] r1, input logic u1,
                        input logic [3:0] r2, input logic u2,
                        input logic rw, input logic [3:0] wa,
                        input logic br, input logic k, input logic [4:0] exp);
        sb_entry_t e;
        @(negedge clk);
        rst = r; validD = v; ra1D = r1; useRa1D = u1; ra2D = r2; useRa2D = u2;
        regWriteD = rw; wa3D = wa; branchD = br; killE = k;
        sb.push_back('{tag: tag, exp: exp});
        #1;
        e = sb.pop_front();
        check(e.tag, {27'd0, stallF, stallD, flushE, issueE, branchBusy}, {27'd0, e.exp});
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, E_IDL);
    endtask

    initial begin
        // 1: reset, then an independent instruction issues in the same cycle
        step("rst0", 1, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, E_RST);
        step("rst1", 1, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, E_RST);
        check("rst_cnt", 32'(stallCnt), 32'd0);
        step("nodep", 0, 1, 4'd1, 1, 4'd2, 1, 0, 4'd0, 0, 0, E_ISS);
        idle("bubble");

        // 2: RAW on R3 via ra1 stalls two cycles; RAW on R5 via ra2
        step("add_r3", 0, 1, 4'd0, 0, 4'd0, 0, 1, 4'd3, 0, 0, E_ISS);
        step("raw1_c1", 0, 1, 4'd3, 1, 4'd0, 0, 0, 4'd0, 0, 0, E_HZ);
        step("raw1_c2", 0, 1, 4'd3, 1, 4'd0, 0, 0, 4'd0, 0, 0, E_HZ);
        step("raw1_iss", 0, 1, 4'd3, 1, 4'd0, 0, 0, 4'd0, 0, 0, E_ISS);
        check("cnt_raw1", 32'(stallCnt), 32'd2);
        step("add_r5", 0, 1, 4'd0, 0, 4'd0, 0, 1, 4'd5, 0, 0, E_ISS);
        step("unused_src", 0, 1, 4'd5, 0, 4'd5, 0, 0, 4'd0, 0, 0, E_ISS);
        step("raw2_c2", 0, 1, 4'd0, 0, 4'd5, 1, 0, 4'd0, 0, 0, E_HZ);
        step("raw2_iss", 0, 1, 4'd0, 0, 4'd5, 1, 0, 4'd0, 0, 0, E_ISS);
        check("cnt_raw2", 32'(stallCnt), 32'd3);
        for (int i = 0; i < 3; i++) idle("drain_a");

        // 3: killed producer never blocks; a bubble never hazards
        step("add_r3_k", 0, 1, 4'd0, 0, 4'd0, 0, 1, 4'd3, 0, 0, E_ISS);
        step("kill_dep", 0, 1, 4'd3, 1, 4'd0, 0, 0, 4'd0, 0, 1, E_ISS);
        step("kill_dep2", 0, 1, 4'd3, 1, 4'd0, 0, 0, 4'd0, 0, 0, E_ISS);
        step("add_r7", 0, 1, 4'd0, 0, 4'd0, 0, 1, 4'd7, 0, 0, E_ISS);
        step("bubble_r7", 0, 0, 4'd7, 1, 4'd7, 1, 0, 4'd0, 0, 0, E_IDL);
        check("cnt_kill", 32'(stallCnt), 32'd3);
        for (int i = 0; i < 3; i++) idle("drain_b");

        // 4: branch issue, two WAIT cycles (killE does not shorten), RELEASE, RUN
        step("br_iss", 0, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1, 0, E_ISS);
        step("br_wait1", 0, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, E_WT);
        step("br_wait2", 0, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, E_WT);
        step("br_rel", 0, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, E_REL);
        step("br_run", 0, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, E_ISS);
        check("cnt_br", 32'(stallCnt), 32'd5);

        // 5: branch blocked by a hazard waits in RUN, then takes the shadow
        step("add_r4", 0, 1, 4'd0, 0, 4'd0, 0, 1, 4'd4, 0, 0, E_ISS);
        step("brhz_c1", 0, 1, 4'd4, 1, 4'd0, 0, 0, 4'd0, 1, 0, E_HZ);
        step("brhz_c2", 0, 1, 4'd4, 1, 4'd0, 0, 0, 4'd0, 1, 0, E_HZ);
        step("brhz_iss", 0, 1, 4'd4, 1, 4'd0, 0, 0, 4'd0, 1, 0, E_ISS);
        step("brhz_w1", 0, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, E_WT);
        step("brhz_w2", 0, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, E_WT);
        step("brhz_rel", 0, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, E_REL);
        idle("brhz_run");
        check("cnt_brhz", 32'(stallCnt), 32'd9);

        // 6a: chain of R1 producers keeps stalling until the counter saturates
        step("chain0", 0, 1, 4'd0, 0, 4'd0, 0, 1, 4'd1, 0, 0, E_ISS);
        for (int i = 0; i < 5; i++) begin
            step("chain_s1", 0, 1, 4'd1, 1, 4'd0, 0, 1, 4'd1, 0, 0, E_HZ);
            step("chain_s2", 0, 1, 4'd1, 1, 4'd0, 0, 1, 4'd1, 0, 0, E_HZ);
            step("chain_iss", 0, 1, 4'd1, 1, 4'd0, 0, 1, 4'd1, 0, 0, E_ISS);
        end
        check("cnt_sat", 32'(stallCnt), 32'd15);
        for (int i = 0; i < 3; i++) idle("drain_c");

        // 6b: reset during WAIT returns to RUN and clears the counter
        step("br2_iss", 0, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1, 0, E_ISS);
        step("br2_wait", 0, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, E_WT);
        step("br2_rst", 1, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, E_RST);
        step("br2_after", 0, 1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, E_ISS);
        check("cnt_rst", 32'(stallCnt), 32'd0);

        // 6c: reset mid-hazard drops the in-flight tag
        step("add_r2", 0, 1, 4'd0, 0, 4'd0, 0, 1, 4'd2, 0, 0, E_ISS);
        step("hz_r2", 0, 1, 4'd2, 1, 4'd0, 0, 0, 4'd0, 0, 0, E_HZ);
        step("hz_rst", 1, 1, 4'd2, 1, 4'd0, 0, 0, 4'd0, 0, 0, E_RST);
        step("hz_after", 0, 1, 4'd2, 1, 4'd0, 0, 0, 4'd0, 0, 0, E_ISS);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
